// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM port arbiter: read-owner tags and pipeline limits.
package vram_arb_pkg;

  localparam int unsigned RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line that carries the owner of each issued VRAM read until its data
// comes back from the memory, so the response can be steered to the requester.
module rd_tag_pipe
  import vram_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  owner_e tag_in,
  output owner_e tag_out
);

  owner_e stage_q [RD_LAT];

  // Reset empties the pipe so in-flight reads never produce a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= OWN_NONE;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares one single-port VRAM between the CPU register path and the HDMI
// scan-out fetch; video wins ties, a bounded wait counter keeps the CPU alive.
module vram_port_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned CPU_MAX_WAIT = 4
) (
  input  logic                  Clk,
  input  logic                  reset_rtl_0,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [DATA_W/8-1:0]   cpu_be,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  vid_req,
  input  logic [ADDR_W-1:0]     vid_addr,
  output logic                  vid_gnt,
  output logic                  vid_rvalid,
  output logic [DATA_W-1:0]     vid_rdata,
  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(CPU_MAX_WAIT + 1);

  logic             arb_en_q;
  logic             force_c;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;
  owner_e           tag_d;
  owner_e           tag_out;

  // Grants stay off until the first edge after reset release.
  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      arb_en_q <= 1'b0;
    end else begin
      arb_en_q <= 1'b1;
    end
  end

  // Priority: starved CPU, then video, then CPU.
  always_comb begin
    cpu_gnt    = 1'b0;
    vid_gnt    = 1'b0;
    tag_d      = OWN_NONE;
    wait_cnt_d = '0;
    force_c    = (wait_cnt_q == CNT_W'(CPU_MAX_WAIT));

    if (arb_en_q) begin
      if (cpu_req && force_c) begin
        cpu_gnt = 1'b1;
      end else if (vid_req) begin
        vid_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end
    end

    if (arb_en_q && cpu_req && !cpu_gnt) begin
      wait_cnt_d = force_c ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
    end

    if (cpu_gnt && !cpu_we) begin
      tag_d = OWN_CPU;
    end else if (vid_gnt) begin
      tag_d = OWN_VID;
    end
  end

  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Registered VRAM port; address/data hold when idle, enables drop.
  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      mem_en    <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= cpu_gnt | vid_gnt;
      mem_we <= cpu_gnt ? (cpu_be & {BE_W{cpu_we}}) : '0;
      if (cpu_gnt) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (vid_gnt) begin
        mem_addr  <= vid_addr;
      end
    end
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (Clk),
    .rst_n   (reset_rtl_0),
    .tag_in  (tag_d),
    .tag_out (tag_out)
  );

  // Steer returning read data to its owner; data holds between pulses.
  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      vid_rvalid <= 1'b0;
      vid_rdata  <= '0;
    end else begin
      cpu_rvalid <= (tag_out == OWN_CPU);
      vid_rvalid <= (tag_out == OWN_VID);
      if (tag_out == OWN_CPU) begin
        cpu_rdata <= mem_rdata;
      end
      if (tag_out == OWN_VID) begin
        vid_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Randomised bench for vram_port_arbiter: a write-first BRAM model on the memory
// port plus a transaction-level reference of grants, memory traffic and read returns.
module tb_vram_port_arbiter;

  localparam int unsigned ADDR_W       = 11;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned BE_W         = DATA_W / 8;
  localparam int unsigned RD_LAT       = 2;
  localparam int unsigned CPU_MAX_WAIT = 4;
  localparam int unsigned MEM_WORDS    = 1 << ADDR_W;

  logic              Clk = 1'b0;
  logic              reset_rtl_0 = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [BE_W-1:0]   cpu_be = '0;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic              vid_gnt, vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  always #5 Clk = ~Clk;

  vram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .CPU_MAX_WAIT(CPU_MAX_WAIT)
  ) dut (
    .Clk(Clk), .reset_rtl_0(reset_rtl_0),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid),
    .vid_rdata(vid_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] wd,
                                              input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old;
    for (int b = 0; b < int'(BE_W); b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Write-first BRAM: registered address cycle plus one memory cycle = RD_LAT 2.
  logic [DATA_W-1:0] bram [MEM_WORDS] = '{default: '0};
  logic [DATA_W-1:0] bram_q = '0;
  always @(posedge Clk) begin
    if (mem_en) begin
      bram[mem_addr] <= merge(bram[mem_addr], mem_wdata, mem_we);
      bram_q         <= merge(bram[mem_addr], mem_wdata, mem_we);
    end
  end
  assign mem_rdata = bram_q;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  rd_exp_t           cpu_q[$], vid_q[$];
  logic [DATA_W-1:0] ref_mem [MEM_WORDS];
  int                n_checks = 0, n_errors = 0, cyc = 0;
  bit                model_on = 1'b0;
  int unsigned       wait_m = 0;
  bit                exp_en = 1'b0, exp_wr = 1'b0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [BE_W-1:0]   exp_we = '0;
  logic [DATA_W-1:0] exp_wdata = '0, last_c = '0, last_v = '0, last_crdata = '0;
  bit                seen_cg, seen_vg, seen_crv, seen_vrv;
  int                cnt_vg = 0, cnt_vrv = 0, cnt_crv = 0, first_vrv = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    cpu_q.delete();
    vid_q.delete();
    wait_m = 0;
    exp_en = 1'b0;
    exp_wr = 1'b0;
    exp_we = '0;
    last_c = '0;
    last_v = '0;
  endtask

  // One cycle of the reference: grant rule, memory port one cycle late, returns RD_LAT+1 late.
  task automatic model_step();
    bit      ecg, evg;
    rd_exp_t e;
    ecg = cpu_req && ((wait_m == CPU_MAX_WAIT) || !vid_req);
    evg = vid_req && !ecg;
    chk("cpu_gnt", 64'(cpu_gnt), 64'(ecg));
    chk("vid_gnt", 64'(vid_gnt), 64'(evg));
    chk("mem_en", 64'(mem_en), 64'(exp_en));
    if (exp_en) begin
      chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
      chk("mem_we", 64'(mem_we), 64'(exp_we));
      if (exp_wr) chk("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
    end
    if (cpu_q.size() != 0 && cpu_q[0].due == cyc) begin
      chk("cpu_rvalid", 64'(cpu_rvalid), 64'(1));
      chk("cpu_rdata", 64'(cpu_rdata), 64'(cpu_q[0].data));
      last_c = cpu_q[0].data;
      void'(cpu_q.pop_front());
    end else begin
      chk("cpu_rvalid", 64'(cpu_rvalid), 64'(0));
      chk("cpu_rdata_hold", 64'(cpu_rdata), 64'(last_c));
    end
    if (vid_q.size() != 0 && vid_q[0].due == cyc) begin
      chk("vid_rvalid", 64'(vid_rvalid), 64'(1));
      chk("vid_rdata", 64'(vid_rdata), 64'(vid_q[0].data));
      last_v = vid_q[0].data;
      void'(vid_q.pop_front());
    end else begin
      chk("vid_rvalid", 64'(vid_rvalid), 64'(0));
      chk("vid_rdata_hold", 64'(vid_rdata), 64'(last_v));
    end
    if (cpu_req && !ecg) wait_m = (wait_m < CPU_MAX_WAIT) ? wait_m + 1 : wait_m;
    else                 wait_m = 0;
    exp_en = ecg || evg;
    exp_wr = ecg && cpu_we;
    exp_we = '0;
    e.due  = cyc + int'(RD_LAT) + 1;
    if (ecg) begin
      exp_addr  = cpu_addr;
      exp_wdata = cpu_wdata;
      if (cpu_we) begin
        exp_we            = cpu_be;
        ref_mem[cpu_addr] = merge(ref_mem[cpu_addr], cpu_wdata, cpu_be);
      end else begin
        e.data = ref_mem[cpu_addr];
        cpu_q.push_back(e);
      end
    end else if (evg) begin
      exp_addr = vid_addr;
      e.data   = ref_mem[vid_addr];
      vid_q.push_back(e);
    end
  endtask

  // Sample on the falling edge, then return just after the next rising edge to drive.
  task automatic tick();
    @(negedge Clk);
    seen_cg  = cpu_gnt;
    seen_vg  = vid_gnt;
    seen_crv = cpu_rvalid;
    seen_vrv = vid_rvalid;
    if (seen_vg) cnt_vg++;
    if (seen_vrv) begin
      cnt_vrv++;
      if (first_vrv < 0) first_vrv = cyc;
    end
    if (seen_crv) begin
      cnt_crv++;
      last_crdata = cpu_rdata;
    end
    if (model_on) model_step();
    else          model_clear();
    @(posedge Clk);
    cyc++;
    #1;
  endtask

  task automatic check_zero();
    chk("rst_cpu_gnt", 64'(cpu_gnt), 64'(0));
    chk("rst_vid_gnt", 64'(vid_gnt), 64'(0));
    chk("rst_cpu_rvalid", 64'(cpu_rvalid), 64'(0));
    chk("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
    chk("rst_vid_rvalid", 64'(vid_rvalid), 64'(0));
    chk("rst_vid_rdata", 64'(vid_rdata), 64'(0));
    chk("rst_mem_en", 64'(mem_en), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(1) == 0) return ADDR_W'($urandom_range(7));
    return ADDR_W'(MEM_WORDS - 1 - $urandom_range(7));
  endfunction

  // Video streams continuously while the CPU reads; returns the CPU request cycles until grant.
  task automatic starve(input logic [ADDR_W-1:0] a, output int n);
    bit done;
    done     = 1'b0;
    n        = 0;
    vid_req  = 1'b1;
    vid_addr = rand_addr();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = a;
    while (!done && n < 20) begin
      tick();
      n++;
      if (seen_cg) done = 1'b1;
      else         vid_addr = rand_addr();
    end
    cpu_req = 1'b0;
    tick();
    vid_req = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    int n, g;
    int p_cpu, p_vid;
    for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = '0;

    // Power-on reset with requests pending: everything must read zero.
    cpu_req = 1'b1;
    vid_req = 1'b1;
    #1 reset_rtl_0 = 1'b0;
    #2 check_zero();
    repeat (2) @(posedge Clk);
    #1;
    cpu_req = 1'b0;
    vid_req = 1'b0;
    @(negedge Clk);
    #1 reset_rtl_0 = 1'b1;
    @(posedge Clk);
    #1;
    model_on = 1'b1;
    repeat (2) tick();

    // Video only: ten back-to-back reads of addresses 0..9.
    cnt_vg = 0; cnt_vrv = 0; first_vrv = -1; g = cyc;
    for (int i = 0; i < 10; i++) begin
      vid_req  = 1'b1;
      vid_addr = ADDR_W'(i);
      tick();
    end
    vid_req = 1'b0;
    repeat (6) tick();
    chk("vid_only_gnt_count", 64'(cnt_vg), 64'(10));
    chk("vid_only_rvalid_count", 64'(cnt_vrv), 64'(10));
    chk("vid_only_first_rvalid", 64'(first_vrv - g), 64'(RD_LAT + 1));

    // Starvation guard: CPU read of the top word under continuous video.
    cnt_crv = 0;
    starve(ADDR_W'(MEM_WORDS - 1), n);
    chk("starve_gnt_cycle", 64'(n), 64'(CPU_MAX_WAIT + 1));
    chk("starve_cpu_rvalid", 64'(cnt_crv), 64'(1));

    // Partial write over zero, then read back.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd5; cpu_wdata = '0; cpu_be = 4'hF;
    tick();
    cpu_wdata = 32'hDEADBEEF; cpu_be = 4'b0101;
    tick();
    cnt_crv = 0;
    cpu_we  = 1'b0;
    tick();
    cpu_req = 1'b0;
    repeat (5) tick();
    chk("wr_rd_rvalid_count", 64'(cnt_crv), 64'(1));
    chk("wr_rd_data", 64'(last_crdata), 64'(32'h00AD00EF));

    // Simultaneous requests with no accumulated wait: video first, CPU next.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd4;
    vid_req = 1'b1; vid_addr = 11'd3;
    tick();
    chk("sim_vid_wins", 64'(seen_vg), 64'(1));
    chk("sim_cpu_denied", 64'(seen_cg), 64'(0));
    vid_req = 1'b0;
    tick();
    chk("sim_cpu_next", 64'(seen_cg), 64'(1));
    cpu_req = 1'b0;
    tick();
    starve(11'd6, n);
    chk("wait_cnt_cleared", 64'(n), 64'(CPU_MAX_WAIT + 1));

    // Reset one cycle after a CPU read grant drops the in-flight read.
    repeat (3) tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd9;
    tick();
    chk("rst_pre_gnt", 64'(seen_cg), 64'(1));
    cpu_addr = 11'd10;
    vid_req  = 1'b1;
    vid_addr = 11'd3;
    model_on = 1'b0;
    #2 reset_rtl_0 = 1'b0;
    #1 check_zero();
    @(negedge Clk);
    #2;
    cpu_req = 1'b0;
    vid_req = 1'b0;
    reset_rtl_0 = 1'b1;
    @(posedge Clk);
    cyc++;
    #1;
    cnt_crv = 0;
    repeat (5) tick();
    chk("rst_no_cpu_rvalid", 64'(cnt_crv), 64'(0));
    model_on = 1'b1;

    // Randomised traffic at several video loads.
    for (int seg = 0; seg < 4; seg++) begin
      p_vid = (seg == 0) ? 30 : (seg == 1) ? 60 : (seg == 2) ? 95 : 100;
      p_cpu = 70;
      for (int k = 0; k < 700; k++) begin
        if (!cpu_req || seen_cg) begin
          if (int'($urandom_range(99)) < p_cpu) begin
            cpu_req   = 1'b1;
            cpu_we    = 1'($urandom_range(1));
            cpu_addr  = rand_addr();
            cpu_wdata = $urandom;
            cpu_be    = BE_W'($urandom);
          end else begin
            cpu_req = 1'b0;
          end
        end
        if (!vid_req || seen_vg) begin
          if (int'($urandom_range(99)) < p_vid) begin
            vid_req  = 1'b1;
            vid_addr = rand_addr();
          end else begin
            vid_req = 1'b0;
          end
        end
        tick();
      end
    end
    for (int k = 0; k < 40; k++) begin
      if (seen_cg) cpu_req = 1'b0;
      if (seen_vg) vid_req = 1'b0;
      tick();
    end
    chk("drain_cpu_req", 64'(cpu_req), 64'(0));
    chk("drain_vid_req", 64'(vid_req), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
